// File: rtl/alu_pkg.sv
// Shared definitions for the enter-driven ALU: opcode values, FSM state
// encoding and a helper that decides whether an opcode runs on the iterative
// multiply/divide unit.
package alu_pkg;

   // Opcodes (0 and 15 are invalid)
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_OR   = 4'd6;
   localparam logic [3:0] OP_SHLA = 4'd7;
   localparam logic [3:0] OP_SHRA = 4'd8;
   localparam logic [3:0] OP_SHLB = 4'd9;
   localparam logic [3:0] OP_SHRB = 4'd10;
   localparam logic [3:0] OP_INCA = 4'd11;
   localparam logic [3:0] OP_DECA = 4'd12;
   localparam logic [3:0] OP_INCB = 4'd13;
   localparam logic [3:0] OP_DECB = 4'd14;

   // FSM state encoding
   localparam logic [2:0] GET_A  = 3'd0;
   localparam logic [2:0] GET_B  = 3'd1;
   localparam logic [2:0] GET_OP = 3'd2;
   localparam logic [2:0] EXEC   = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;

   // Multiply always iterates; divide iterates unless the divisor is zero.
   function automatic logic is_iter(input logic [3:0] op, input logic b_zero);
      return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per clock.
// The first bit is processed on the start edge itself, so the result is
// ready (done_o high) after WIDTH-1 further edges.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       launch a new operation (operands taken from a_i/b_i)
//   sel_div_i     1 = divide, 0 = multiply (sampled with start_i)
//   a_i, b_i      multiplicand/multiplier or dividend/divisor
//   done_o        result valid, held until the next start
//   res_o         product, or {remainder, quotient}
module alu_muldiv_iter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               sel_div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] res_o
);

   localparam int unsigned RW = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH);

   logic             run_q, done_q, sel_q;
   logic [CW-1:0]    cnt_q;
   logic [RW-1:0]    acc_q, mcand_q;
   logic [WIDTH-1:0] mplier_q, rem_q, dq_q, dvs_q;

   logic [RW-1:0]    acc_s, mcand_s, acc_n, mcand_n;
   logic [WIDTH-1:0] mplier_s, rem_s, dq_s, dvs_s;
   logic [WIDTH-1:0] mplier_n, rem_n, dq_n;
   logic [WIDTH:0]   trial_c;
   logic             ge_c;

   // Step operands: fresh inputs on the start edge, stored state otherwise
   always_comb begin
      acc_s    = start_i ? '0          : acc_q;
      mcand_s  = start_i ? RW'(a_i)    : mcand_q;
      mplier_s = start_i ? b_i         : mplier_q;
      rem_s    = start_i ? '0          : rem_q;
      dq_s     = start_i ? a_i         : dq_q;
      dvs_s    = start_i ? b_i         : dvs_q;
   end

   // One multiply step and one restoring-divide step
   always_comb begin
      acc_n    = acc_s + (mplier_s[0] ? mcand_s : '0);
      mcand_n  = mcand_s << 1;
      mplier_n = mplier_s >> 1;
      trial_c  = {rem_s, dq_s[WIDTH-1]};
      ge_c     = (trial_c >= {1'b0, dvs_s});
      // Remainder always stays below the divisor, so WIDTH bits suffice
      rem_n    = ge_c ? WIDTH'(trial_c - {1'b0, dvs_s}) : WIDTH'(trial_c);
      dq_n     = {dq_s[WIDTH-2:0], ge_c};
   end

   // Iteration state
   always_ff @(posedge clk) begin
      if (rst) begin
         run_q    <= 1'b0;
         done_q   <= 1'b0;
         sel_q    <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         dq_q     <= '0;
         dvs_q    <= '0;
      end else if (start_i || run_q) begin
         acc_q    <= acc_n;
         mcand_q  <= mcand_n;
         mplier_q <= mplier_n;
         rem_q    <= rem_n;
         dq_q     <= dq_n;
         dvs_q    <= dvs_s;
         if (start_i) begin
            run_q  <= 1'b1;
            done_q <= 1'b0;
            sel_q  <= sel_div_i;
            cnt_q  <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 2)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign res_o  = sel_q ? {rem_q, dq_q} : acc_q;

endmodule

// File: rtl/alu_fsm_param.sv
// Enter-driven ALU: A, B and the opcode are captured one per enter press,
// then the operation executes and the registered result/flags are shown.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enter           debounced load/advance strobe (rising edge acts)
//   in_A, in_B      operands, WIDTH bits
//   oper            4-bit opcode
//   result          registered 2*WIDTH-bit result
//   valid, busy     completion / execution-in-progress handshake
//   carry, zero,err result flags, updated with result
module alu_fsm_param
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enter,
   input  logic [WIDTH-1:0]   in_A,
   input  logic [WIDTH-1:0]   in_B,
   input  logic [3:0]         oper,
   output logic [2*WIDTH-1:0] result,
   output logic               valid,
   output logic               busy,
   output logic               carry,
   output logic               zero,
   output logic               err
);

   localparam int unsigned RW = 2 * WIDTH;

   logic [2:0]       state_q, state_d;
   logic             enter_q, rise_c;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic [RW-1:0]    result_q, result_d;
   logic             valid_q, valid_d, busy_q, busy_d;
   logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d;

   logic             start_c, md_done;
   logic [RW-1:0]    md_res;

   logic [WIDTH:0]   add_c;
   logic [WIDTH-1:0] inc_a_c, dec_a_c, inc_b_c, dec_b_c;
   logic [RW-1:0]    alu_res_c;
   logic             alu_carry_c, alu_err_c;

   logic             fin_c;
   logic [RW-1:0]    fin_res_c;
   logic             fin_carry_c, fin_err_c;

   assign rise_c = enter & ~enter_q;

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_c),
      .sel_div_i (oper == OP_DIV),
      .a_i       (a_q),
      .b_i       (b_q),
      .done_o    (md_done),
      .res_o     (md_res)
   );

   assign add_c   = {1'b0, a_q} + {1'b0, b_q};
   assign inc_a_c = a_q + WIDTH'(1);
   assign dec_a_c = a_q - WIDTH'(1);
   assign inc_b_c = b_q + WIDTH'(1);
   assign dec_b_c = b_q - WIDTH'(1);

   // Single-cycle operations
   always_comb begin
      alu_res_c   = '0;
      alu_carry_c = 1'b0;
      alu_err_c   = 1'b0;
      case (op_q)
         OP_ADD:  begin alu_res_c = RW'(add_c);   alu_carry_c = add_c[WIDTH];   end
         OP_SUB:  begin alu_res_c = RW'(a_q) - RW'(b_q); alu_carry_c = (a_q < b_q); end
         OP_MUL, OP_DIV: ;
         OP_AND:  alu_res_c = RW'(a_q & b_q);
         OP_OR:   alu_res_c = RW'(a_q | b_q);
         OP_SHLA: alu_res_c = RW'({a_q, 1'b0});
         OP_SHRA: alu_res_c = RW'(a_q >> 1);
         OP_SHLB: alu_res_c = RW'({b_q, 1'b0});
         OP_SHRB: alu_res_c = RW'(b_q >> 1);
         OP_INCA: begin alu_res_c = RW'(inc_a_c); alu_carry_c = &a_q;          end
         OP_DECA: begin alu_res_c = RW'(dec_a_c); alu_carry_c = (a_q == '0);   end
         OP_INCB: begin alu_res_c = RW'(inc_b_c); alu_carry_c = &b_q;          end
         OP_DECB: begin alu_res_c = RW'(dec_b_c); alu_carry_c = (b_q == '0);   end
         default: alu_err_c = 1'b1;
      endcase
   end

   // Completion select: iterative unit, divide-by-zero, or single-cycle
   always_comb begin
      fin_c       = 1'b1;
      fin_res_c   = alu_res_c;
      fin_carry_c = alu_carry_c;
      fin_err_c   = alu_err_c;
      if (is_iter(op_q, b_q == '0)) begin
         fin_c       = md_done;
         fin_res_c   = md_res;
         fin_carry_c = 1'b0;
         fin_err_c   = 1'b0;
      end else if (op_q == OP_DIV) begin
         fin_res_c   = '1;
         fin_carry_c = 1'b0;
         fin_err_c   = 1'b1;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      err_d    = err_q;
      start_c  = 1'b0;
      case (state_q)
         GET_A: if (rise_c) begin
            a_d     = in_A;
            state_d = GET_B;
         end
         GET_B: if (rise_c) begin
            b_d     = in_B;
            state_d = GET_OP;
         end
         GET_OP: if (rise_c) begin
            op_d    = oper;
            valid_d = 1'b0;
            busy_d  = 1'b1;
            start_c = is_iter(oper, b_q == '0);
            state_d = EXEC;
         end
         EXEC: if (fin_c) begin
            result_d = fin_res_c;
            zero_d   = (fin_res_c == '0);
            carry_d  = fin_carry_c;
            err_d    = fin_err_c;
            valid_d  = 1'b1;
            busy_d   = 1'b0;
            state_d  = DONE;
         end
         DONE: if (rise_c) begin
            valid_d = 1'b0;
            state_d = GET_A;
         end
         default: state_d = GET_A;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= GET_A;
         enter_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         enter_q  <= enter;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   assign result = result_q;
   assign valid  = valid_q;
   assign busy   = busy_q;
   assign carry  = carry_q;
   assign zero   = zero_q;
   assign err    = err_q;

endmodule

// File: tb/tb_alu_fsm_param.sv
// Self-checking bench for alu_fsm_param (WIDTH=4): directed scenarios plus
// random operations compared against an arithmetic reference model.
module tb_alu_fsm_param;

   localparam int unsigned W  = 4;
   localparam int unsigned RW = 2 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          enter;
   logic [W-1:0]  in_a, in_b;
   logic [3:0]    oper;
   logic [RW-1:0] result;
   logic          valid, busy, carry, zero, err;

   int n_checks = 0;
   int n_errors = 0;
   bit in_done  = 1'b0;

   always #5 clk = ~clk;

   alu_fsm_param #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .enter  (enter),
      .in_A   (in_a),
      .in_B   (in_b),
      .oper   (oper),
      .result (result),
      .valid  (valid),
      .busy   (busy),
      .carry  (carry),
      .zero   (zero),
      .err    (err)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model straight from the opcode table
   function automatic void model(input int unsigned op, a, b,
                                 output int unsigned res, cy, er, lat);
      int unsigned m, rm;
      m   = (1 << W) - 1;
      rm  = (1 << RW) - 1;
      res = 0; cy = 0; er = 0; lat = 1;
      case (op)
         1:  begin res = a + b; cy = (a + b) >> W; end
         2:  begin res = (a - b) & rm; cy = (a < b) ? 1 : 0; end
         3:  begin res = a * b; lat = W; end
         4:  if (b == 0) begin res = rm; er = 1; end
             else begin res = ((a % b) << W) | (a / b); lat = W; end
         5:  res = a & b;
         6:  res = a | b;
         7:  res = a << 1;
         8:  res = a >> 1;
         9:  res = b << 1;
         10: res = b >> 1;
         11: begin res = (a + 1) & m; cy = (a == m) ? 1 : 0; end
         12: begin res = (a - 1) & m; cy = (a == 0) ? 1 : 0; end
         13: begin res = (b + 1) & m; cy = (b == m) ? 1 : 0; end
         14: begin res = (b - 1) & m; cy = (b == 0) ? 1 : 0; end
         default: er = 1;
      endcase
   endfunction

   // One enter press; gap adds a low cycle so back-to-back presses rise again
   task automatic press(input bit gap);
      enter = 1'b1;
      @(negedge clk);
      enter = 1'b0;
      if (gap) @(negedge clk);
   endtask

   task automatic leave_done();
      if (in_done) begin
         press(1'b1);
         check("leave_done_valid", valid, 0);
         in_done = 1'b0;
      end
   endtask

   // Press the opcode and check latency, busy length, result and flags
   task automatic exec_op(input int unsigned op, a, b, input bit poke);
      int unsigned e_res, e_cy, e_er, e_lat, lat, nbusy;
      model(op, a, b, e_res, e_cy, e_er, e_lat);
      oper = 4'(op);
      press(1'b0);
      check("valid_clear", valid, 0);
      lat = 0; nbusy = 0;
      while (!valid && lat < 100) begin
         if (busy) nbusy++;
         if (poke && lat == 1) enter = 1'b1;
         if (poke && lat == 2) enter = 1'b0;
         @(negedge clk);
         lat++;
      end
      enter = 1'b0;
      check($sformatf("latency op%0d", op), lat, e_lat);
      check($sformatf("busy_cycles op%0d", op), nbusy, e_lat);
      check("busy_fall", busy, 0);
      check($sformatf("result op%0d a%0d b%0d", op, a, b), result, e_res);
      check($sformatf("carry op%0d", op), carry, e_cy);
      check($sformatf("zero op%0d", op), zero, (e_res == 0) ? 1 : 0);
      check($sformatf("err op%0d", op), err, e_er);
      if (poke) begin
         repeat (3) @(negedge clk);
         check("exec_rise_dropped", valid, 1);
      end
      in_done = 1'b1;
   endtask

   task automatic run_op(input int unsigned op, a, b, input bit poke);
      leave_done();
      in_a = W'(a);
      press(1'b1);
      in_b = W'(b);
      press(1'b1);
      exec_op(op, a, b, poke);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_result"}, result, 0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_carry"}, carry, 0);
      check({tag, "_zero"}, zero, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      rst = 1'b1; enter = 1'b0; in_a = '0; in_b = '0; oper = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      run_op(1, 8, 2, 0);
      run_op(1, 15, 8, 0);
      run_op(2, 15, 8, 0);
      run_op(2, 2, 8, 0);
      run_op(3, 9, 9, 1);
      run_op(4, 8, 2, 0);
      run_op(4, 7, 0, 0);

      // Holding enter captures A only once
      leave_done();
      in_a = 4'd3;
      enter = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_a = W'($urandom);
         in_b = W'($urandom);
      end
      enter = 1'b0;
      @(negedge clk);
      check("hold_valid", valid, 0);
      check("hold_busy", busy, 0);
      in_b = 4'd5;
      press(1'b1);
      exec_op(1, 3, 5, 0);

      run_op(0, 6, 3, 0);

      // Reset on the second multiply cycle
      leave_done();
      in_a = 4'd5; press(1'b1);
      in_b = 4'd3; press(1'b1);
      oper = 4'd3; press(1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("midmul_reset");
      repeat (6) @(negedge clk);
      check("midmul_no_complete", valid, 0);
      in_done = 1'b0;
      run_op(1, 1, 1, 0);

      run_op(7, 8, 0, 0);
      run_op(12, 0, 0, 0);
      run_op(13, 0, 15, 0);

      // Random operations, divisor forced to zero now and then
      for (int i = 0; i < 80; i++) begin
         int unsigned op, a, b;
         op = $urandom_range(0, 15);
         a  = $urandom_range(0, (1 << W) - 1);
         b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, (1 << W) - 1);
         run_op(op, a, b, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_fsm_param.md
# alu_fsm_param

Parametrised successor to the 4-bit enter-driven ALU. Operands A and B and the opcode are loaded one per `enter` press into a clocked FSM, which then executes one of 14 operations. Width is set by `WIDTH`. Multiply and divide are iterative (one bit per clock). The block adds busy/valid handshaking plus carry, zero and error flags. It sits behind the board switch/pushbutton front end and drives the result display path.

## Interface
- `WIDTH`, default 4: operand width in bits. Legal range is 2..16. The result is 2·`WIDTH` bits.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enter`  in  1  load/advance strobe. It is already debounced and synchronous to `clk`; only its rising edge acts.
- `in_A`  in  `WIDTH`  operand A.
- `in_B`  in  `WIDTH`  operand B.
- `oper`  in  4  opcode.
- `result`  out  2·`WIDTH`  registered result.
- `valid`  out  1  `result` is the completed value for the current operand set.
- `busy`  out  1  execution in progress.
- `carry`  out  1  carry-out or borrow of the last operation.
- `zero`  out  1  `result` == 0 (registered alongside `result`).
- `err`  out  1  divide by zero, or an invalid opcode.

## Operation
- Edge detect: `enter_q` registers `enter`; `rise = enter & ~enter_q`. Holding `enter` high yields exactly one rise.
- FSM states and transitions:
  - GET_A: on rise, `a_reg <= in_A`, go to GET_B.
  - GET_B: on rise, `b_reg <= in_B`, go to GET_OP.
  - GET_OP: on rise, `op_reg <= oper`, clear `valid`, go to EXEC with `cnt <= 0`.
  - EXEC: `busy` = 1 and rise is ignored. Go to DONE when the operation completes.
  - DONE: `valid` = 1. On rise, clear `valid` and go to GET_A. `result` and the flags hold until the next completion.
- Opcodes (result zero-extended to 2·`WIDTH` unless stated otherwise):
  - 1: A+B. `carry` = bit `WIDTH`.
  - 2: A−B as 2·`WIDTH` two's complement. `carry` = (A<B).
  - 3: A·B, full product.
  - 4: A/B. Quotient in the low half, remainder in the high half.
  - 5: A&B.
  - 6: A|B.
  - 7: A<<1, no bit lost (bit `WIDTH` holds the old MSB).
  - 8: A>>1.
  - 9: B<<1.
  - 10: B>>1.
  - 11: A+1, `carry` on wrap of `WIDTH` bits.
  - 12: A−1, computed mod 2^`WIDTH` in the low half. `carry` = (A==0).
  - 13: B+1, as opcode 11.
  - 14: B−1, as opcode 12.
- Opcodes 0 and 15: `result` = 0, `err` = 1.
- Divide with B = 0: `result` = all ones, `err` = 1, completes after 1 cycle.
- `carry` is 0 for all opcodes that do not define it. `err` is cleared on every completion that has no error.
- Reset: all outputs, registers and `cnt` go to 0 and the FSM goes to GET_A. This applies in any state, including in the middle of a multiply or divide.

## Timing
- Capture: each rise is acted on at the first `clk` edge where it is sampled. There is one capture per press.
- Latency is counted from the GET_OP capture edge to the edge that sets `valid`:
  - opcodes 1, 2 and 5–15: 1 cycle.
  - 3 and 4: `WIDTH` cycles. `busy` is high for exactly `WIDTH` cycles.
  - divide by zero: 1 cycle.
- `result`, `carry`, `zero` and `err` update on the same edge that sets `valid`. `busy` falls on that edge.
- A rise during EXEC is dropped and is not queued.
- Reset has priority over rise on the same edge.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams OP_ADD..OP_DECB.
  - FSM state encoding GET_A, GET_B, GET_OP, EXEC, DONE.
- Sub-module `alu_muldiv_iter`: `WIDTH`-parameterised shift-add multiplier and restoring divider, one bit per cycle.
  - Inputs: start, sel_div, a, b.
  - Outputs: done, product/quotient-remainder.
  - The top level owns the FSM and the single-cycle operations.

## Test plan
All scenarios use `WIDTH`=4.
- Add 8+2: `result` = 0x0A, `carry` = 0, `valid` 1 cycle after the op capture.
- Add 15+8: `result` = 0x17, `carry` = 1.
- Sub 15−8: `result` = 0x07, `carry` = 0.
- Sub 2−8: `result` = 0xFA, `carry` = 1.
- Mul 9·9: `result` = 0x51. `busy` is high for 4 cycles and `valid` rises on the 4th edge. A rise during EXEC is ignored.
- Div 8/2: `result` = 0x04, `err` = 0.
- Div 7/0: `result` = 0xFF, `err` = 1.
- Hold `enter` high for 10 cycles in GET_A: only A is captured and the FSM stays in GET_B.
- Opcode 0: `result` = 0x00, `err` = 1, `zero` = 1.
- Assert `rst` on the 2nd multiply cycle: next edge gives all outputs 0 and state GET_A. A following add 1+1 gives 0x02 cleanly.
- Left shift A=8: 0x10.
- Decrement A=0: 0x0F, `carry` = 1.
- Increment B=15: 0x00, `carry` = 1, `zero` = 1.
